// File: rtl/layer_sequencer.sv
// Run controller that launches conv layer engines in ascending order,
// with a per-run skip mask, watchdog, abort and error reporting.
module layer_sequencer #(
    parameter int NUM_LAYERS = 6,
    parameter int SEL_W      = 3,
    parameter int TIMEOUT_W  = 24,
    parameter int CYC_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    output logic [NUM_LAYERS-1:0] layer_init,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [SEL_W-1:0]      layer_sel,
    output logic                  busy,
    input  logic [3:0]            label_in,
    output logic [3:0]            label,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [SEL_W-1:0]      err_layer,
    output logic [CYC_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ABORT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SPUR    = 2'd3;

    state_t                state;
    state_t                state_n;
    logic [NUM_LAYERS-1:0] mask;
    logic [NUM_LAYERS-1:0] mask_n;
    logic [TIMEOUT_W-1:0]  limit;
    logic [TIMEOUT_W-1:0]  limit_n;
    logic [TIMEOUT_W-1:0]  wdog;
    logic [TIMEOUT_W-1:0]  wdog_n;
    logic [TIMEOUT_W-1:0]  wdog_inc;
    logic [SEL_W-1:0]      sel_n;
    logic [3:0]            label_n;
    logic                  done_n;
    logic                  error_n;
    logic [1:0]            code_n;
    logic [SEL_W-1:0]      elayer_n;
    logic [CYC_W-1:0]      cyc_n;
    logic [1:0]            fail_code;

    logic [NUM_LAYERS-1:0] sel_hot;
    logic                  hit;
    logic                  spurious;
    logic                  expired;
    logic                  has_next;
    logic [SEL_W-1:0]      next_sel;
    logic [SEL_W-1:0]      first_sel;

    assign sel_hot    = NUM_LAYERS'(1) << layer_sel;
    assign layer_init = (state == LAUNCH) ? sel_hot : '0;
    assign busy       = (state != IDLE);
    assign hit        = |(layer_done & sel_hot);
    assign spurious   = |(layer_done & ~sel_hot);
    assign wdog_inc   = wdog + TIMEOUT_W'(1);
    assign expired    = (state == WAIT) && (limit != '0) &&
                        (wdog_inc == limit);

    // Lowest set bit of the incoming mask picks the first layer.
    always_comb begin
        first_sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_mask[i]) first_sel = SEL_W'(i);
        end
    end

    always_comb begin
        next_sel = '0;
        has_next = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) > layer_sel)) begin
                next_sel = SEL_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        mask_n    = mask;
        limit_n   = limit;
        wdog_n    = wdog;
        sel_n     = layer_sel;
        label_n   = label;
        done_n    = 1'b0;
        error_n   = error;
        code_n    = err_code;
        elayer_n  = err_layer;
        cyc_n     = cycle_count;
        fail_code = ERR_NONE;

        if ((state != IDLE) && (cycle_count != '1)) begin
            cyc_n = cycle_count + CYC_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (init) begin
                    mask_n   = layer_mask;
                    limit_n  = timeout_limit;
                    cyc_n    = '0;
                    error_n  = 1'b0;
                    code_n   = ERR_NONE;
                    elayer_n = '0;
                    if (|layer_mask) begin
                        sel_n   = first_sel;
                        state_n = LAUNCH;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            LAUNCH, WAIT: begin
                // abort > spurious > valid done > timeout
                if (abort) begin
                    fail_code = ERR_ABORT;
                end else if (spurious) begin
                    fail_code = ERR_SPUR;
                end else if (hit) begin
                    if (has_next) begin
                        sel_n   = next_sel;
                        state_n = LAUNCH;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        label_n = label_in;
                    end
                end else if (expired) begin
                    fail_code = ERR_TIMEOUT;
                end else if (state == LAUNCH) begin
                    state_n = WAIT;
                    wdog_n  = '0;
                end else begin
                    wdog_n = wdog_inc;
                end

                if (fail_code != ERR_NONE) begin
                    state_n  = IDLE;
                    done_n   = 1'b1;
                    error_n  = 1'b1;
                    code_n   = fail_code;
                    elayer_n = layer_sel;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            mask        <= '0;
            limit       <= '0;
            wdog        <= '0;
            layer_sel   <= '0;
            label       <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= '0;
            err_layer   <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            mask        <= mask_n;
            limit       <= limit_n;
            wdog        <= wdog_n;
            layer_sel   <= sel_n;
            label       <= label_n;
            done        <= done_n;
            error       <= error_n;
            err_code    <= code_n;
            err_layer   <= elayer_n;
            cycle_count <= cyc_n;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed runs with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_layer_sequencer;

    localparam int NL = 6;
    localparam int SW = 3;
    localparam int TW = 24;
    localparam int CW = 32;
    localparam longint CYC_MAX = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          init = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_mask = '0;
    logic [NL-1:0] layer_done = '0;
    logic [TW-1:0] timeout_limit = '0;
    logic [3:0]    label_in = '0;
    logic [NL-1:0] layer_init;
    logic [SW-1:0] layer_sel;
    logic [SW-1:0] err_layer;
    logic          busy;
    logic          done;
    logic          error;
    logic [3:0]    label;
    logic [1:0]    err_code;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .init         (init),
        .abort        (abort),
        .layer_mask   (layer_mask),
        .timeout_limit(timeout_limit),
        .layer_init   (layer_init),
        .layer_done   (layer_done),
        .layer_sel    (layer_sel),
        .busy         (busy),
        .label_in     (label_in),
        .label        (label),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_layer    (err_layer),
        .cycle_count  (cycle_count)
    );

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural model: phase 0 idle, 1 launch, 2 wait.
    int            m_ph = 0;
    int            m_sel = 0;
    int            m_code = 0;
    int            m_el = 0;
    int            nx = 0;
    longint        m_wd = 0;
    longint        m_lim = 0;
    longint        m_cyc = 0;
    logic [NL-1:0] m_mask = '0;
    logic [3:0]    m_label = '0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;

    function automatic int next_layer(input logic [NL-1:0] mk, input int from);
        for (int i = from; i < NL; i++) if (mk[i]) return i;
        return -1;
    endfunction

    task automatic m_fail(input int code);
        m_ph = 0;
        m_done = 1'b1;
        m_err = 1'b1;
        m_code = code;
        m_el = m_sel;
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_ph = 0; m_sel = 0; m_code = 0; m_el = 0;
            m_wd = 0; m_lim = 0; m_cyc = 0; m_mask = '0;
            m_label = '0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_ph != 0 && m_cyc < CYC_MAX) m_cyc++;
            if (m_ph == 0) begin
                if (init) begin
                    m_mask = layer_mask;
                    m_lim = longint'(timeout_limit);
                    m_cyc = 0; m_err = 1'b0; m_code = 0; m_el = 0;
                    if (m_mask == '0) m_done = 1'b1;
                    else begin
                        m_sel = next_layer(m_mask, 0);
                        m_ph = 1;
                    end
                end
            end else if (abort) begin
                m_fail(1);
            end else if ((layer_done & ~(NL'(1) << m_sel)) != '0) begin
                m_fail(3);
            end else if (layer_done[m_sel]) begin
                nx = next_layer(m_mask, m_sel + 1);
                if (nx >= 0) begin
                    m_sel = nx;
                    m_ph = 1;
                end else begin
                    m_ph = 0;
                    m_done = 1'b1;
                    m_label = label_in;
                end
            end else if (m_ph == 2 && m_lim != 0 && m_wd + 1 >= m_lim) begin
                m_fail(2);
            end else if (m_ph == 1) begin
                m_ph = 2;
                m_wd = 0;
            end else begin
                m_wd++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 64'(busy), 64'(m_ph != 0));
            chk("layer_init", 64'(layer_init),
                (m_ph == 1) ? (64'(1) << m_sel) : 64'(0));
            chk("layer_sel", 64'(layer_sel), 64'(m_sel));
            chk("done", 64'(done), 64'(m_done));
            chk("error", 64'(error), 64'(m_err));
            chk("err_code", 64'(err_code), 64'(m_code));
            chk("err_layer", 64'(err_layer), 64'(m_el));
            chk("label", 64'(label), 64'(m_label));
            chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
        end
    end

    logic [NL-1:0] seen_init;
    logic [63:0]   order;
    int            n_dp;
    int            done_at;
    int            r;

    // ev_kind: 0 none, 1 abort with done at ev_layer,
    // 2 spurious done[1] instead at ev_layer, 3 init pulse while busy
    task automatic run(input logic [NL-1:0] mk, input logic [TW-1:0] lim,
                       input int dly, input int ev_layer, input int ev_kind,
                       input int budget);
        int cd;
        int cur;
        cd = 0;
        cur = 0;
        seen_init = '0; order = '0; n_dp = 0; done_at = -1;
        layer_mask = mk; timeout_limit = lim; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                n_dp++;
                if (done_at < 0) done_at = c;
            end
            layer_done = '0;
            abort = 1'b0;
            init = 1'b0;
            if (c == 2 && ev_kind == 3) begin
                init = 1'b1;
                layer_mask = '1;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (ev_kind == 2 && cur == ev_layer) layer_done[1] = 1'b1;
                    else begin
                        layer_done[cur] = 1'b1;
                        abort = (ev_kind == 1 && cur == ev_layer);
                    end
                end
            end
            if (layer_init != '0) begin
                seen_init |= layer_init;
                order = order * 8 + 64'(layer_sel) + 1;
                cur = int'(layer_sel);
                cd = dly - 1;
            end
            @(negedge clk);
        end
        layer_done = '0; abort = 1'b0; init = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sel", 64'(layer_sel), 64'(0));
        chk("rst_init", 64'(layer_init), 64'(0));
        chk("rst_cycles", 64'(cycle_count), 64'(0));
        chk_on = 1'b1;
        rstn = 1'b1;
        @(negedge clk);

        label_in = 4'd7;
        run(6'b111111, '0, 2, -1, 0, 30);
        chk("all_order", order, 64'o123456);
        chk("all_seen", 64'(seen_init), 64'h3f);
        chk("all_npulse", 64'(n_dp), 64'(1));
        chk("all_done_at", 64'(done_at), 64'(12));
        chk("all_label", 64'(label), 64'(7));
        chk("all_error", 64'(error), 64'(0));

        label_in = 4'd2;
        run(6'b000000, '0, 2, -1, 0, 10);
        chk("zero_done_at", 64'(done_at), 64'(0));
        chk("zero_npulse", 64'(n_dp), 64'(1));
        chk("zero_error", 64'(error), 64'(0));
        chk("zero_cycles", 64'(cycle_count), 64'(0));
        chk("zero_label", 64'(label), 64'(7));

        run(6'b000001, '0, 4, -1, 0, 12);
        chk("one_done_at", 64'(done_at), 64'(4));
        chk("one_cycles", 64'(cycle_count), 64'(4));
        chk("one_label", 64'(label), 64'(2));

        run(6'b101010, '0, 2, -1, 3, 20);
        chk("skip_order", order, 64'o246);
        chk("skip_seen", 64'(seen_init), 64'h2a);
        chk("skip_npulse", 64'(n_dp), 64'(1));
        chk("skip_done_at", 64'(done_at), 64'(6));

        run(6'b000100, TW'(10), 1000, -1, 0, 20);
        chk("tmo_done_at", 64'(done_at), 64'(11));
        chk("tmo_error", 64'(error), 64'(1));
        chk("tmo_code", 64'(err_code), 64'(2));
        chk("tmo_layer", 64'(err_layer), 64'(2));
        chk("tmo_cycles", 64'(cycle_count), 64'(11));

        run(6'b111111, '0, 2, 3, 1, 20);
        chk("abort_code", 64'(err_code), 64'(1));
        chk("abort_layer", 64'(err_layer), 64'(3));
        chk("abort_no_l4", 64'(seen_init[4]), 64'(0));
        chk("abort_npulse", 64'(n_dp), 64'(1));

        run(6'b111111, '0, 2, 3, 2, 20);
        chk("spur_code", 64'(err_code), 64'(3));
        chk("spur_layer", 64'(err_layer), 64'(3));

        layer_mask = 6'b000100; timeout_limit = '0; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_error", 64'(error), 64'(0));
        chk("mid_rst_code", 64'(err_code), 64'(0));
        chk("mid_rst_sel", 64'(layer_sel), 64'(0));
        chk("mid_rst_cycles", 64'(cycle_count), 64'(0));
        rstn = 1'b1;
        n_dp = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_dp++;
        end
        chk("mid_rst_nodone", 64'(n_dp), 64'(0));

        for (int c = 0; c < 4000; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            init = ($urandom_range(0, 7) == 0);
            layer_mask = NL'($urandom);
            if ($urandom_range(0, 15) == 0) layer_mask = '0;
            timeout_limit = ($urandom_range(0, 3) == 0) ? '0
                          : TW'($urandom_range(1, 12));
            label_in = 4'($urandom);
            abort = ($urandom_range(0, 59) == 0);
            layer_done = '0;
            r = $urandom_range(0, 99);
            if (r < 30) layer_done[m_sel] = 1'b1;
            else if (r < 33) layer_done[$urandom_range(0, NL - 1)] = 1'b1;
            @(negedge clk);
        end

        rstn = 1'b1; init = 1'b0; abort = 1'b0; layer_done = '0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Parameterised run controller that sequences up to NUM_LAYERS conv layer engines sharing the param/fmap bank ports of the inference core. It issues one-cycle init pulses, drives the bank-mux select, and waits for each layer's done. It supports a per-run layer skip mask, a watchdog timeout, abort, a run cycle counter and error reporting. It replaces hard-coded per-layer state chains in the core top.

Parameters:
NUM_LAYERS, 6, number of layer engines; engine i is launched in ascending index order.
SEL_W, 3, width of layer_sel and err_layer; 2^SEL_W must be >= NUM_LAYERS.
TIMEOUT_W, 24, watchdog counter and limit width.
CYC_W, 32, run cycle counter width.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
init  in  1  start request; accepted only in IDLE
abort  in  1  terminate the current run
layer_mask  in  NUM_LAYERS  bit i=1 runs layer i; sampled at init accept
timeout_limit  in  TIMEOUT_W  max WAIT cycles per layer; 0 disables the watchdog; sampled at init accept
layer_init  out  NUM_LAYERS  one-hot, one-cycle launch pulse to the engines
layer_done  in  NUM_LAYERS  done pulses from the engines
layer_sel  out  SEL_W  index of the current layer; drives the core's bank muxes
busy  out  1  high whenever state != IDLE
label_in  in  4  classifier result from the last layer engine
label  out  4  captured result
done  out  1  one-cycle end-of-run pulse
error  out  1  run ended abnormally
err_code  out  2  0 none, 1 abort, 2 timeout, 3 spurious done
err_layer  out  SEL_W  layer_sel value at the error
cycle_count  out  CYC_W  run length in cycles

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE.
  - All outputs reset to 0: layer_init, layer_sel, busy, label, done, error, err_code, err_layer, cycle_count.
  - Internal mask, limit and watchdog registers reset to 0.
- States:
  - IDLE: no run active.
  - LAUNCH: exactly 1 cycle; layer_init = one-hot(layer_sel), else 0.
  - WAIT: waiting for the selected layer's done.
- Init accept (IDLE, init=1 at edge):
  - Latch mask and limit.
  - Clear cycle_count, error, err_code, err_layer.
  - If latched mask != 0: layer_sel <= lowest set bit index; state <= LAUNCH.
  - If mask == 0: stay IDLE, done=1 next cycle, error=0, cycle_count=0, label unchanged.
- init while busy is ignored. layer_done while IDLE is ignored.
- LAUNCH -> WAIT unconditionally; watchdog <= 0.
- LAUNCH and WAIT share the following layer_done handling:
  - layer_done[layer_sel]=1 with another set mask bit above layer_sel: layer_sel <= next such index; state <= LAUNCH. The next init pulse appears the cycle after done is sampled.
  - layer_done[layer_sel]=1 and no higher mask bit: state <= IDLE; done=1 next cycle; label <= label_in, sampled in the same cycle as the final done.
  - Any layer_done bit other than layer_sel high: spurious-done error, code 3. Takes priority over a simultaneous valid done.
- Watchdog:
  - Increments each WAIT cycle.
  - If limit != 0 and the watchdog reaches limit (i.e. limit WAIT cycles without done): timeout error, code 2.
  - A valid done on the same edge the limit is hit wins; no error.
- Abort: abort=1 in LAUNCH or WAIT gives an abort error, code 1. It has the highest priority over done, timeout and spurious. abort in IDLE is ignored.
- Error termination: state <= IDLE; done=1 next cycle; error=1; err_code set; err_layer <= layer_sel; label unchanged.
- Output holding:
  - done is a 1-cycle pulse.
  - error, err_code, err_layer, label and cycle_count hold until the next init accept.
  - layer_sel holds its last value in IDLE.
- cycle_count: +1 on every edge where state != IDLE, including the terminating edge; saturates at all-ones.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse is issued.

Test Plan:
- mask=6'b111111, limit=0, each engine pulses done 2 edges after its init pulse:
  - layer_init pulses bits 0..5 in order.
  - layer_sel steps 0..5.
  - done pulse once; label=label_in value at the final done (e.g. 4'd7); error=0.
- mask=6'b000001; layer_done[0] sampled on the 4th edge after init accept -> cycle_count=4; done the next cycle; busy low with done.
- mask=6'b101010 -> only layers 1, 3, 5 launched; layer_init never has bits 0, 2 or 4 set.
- mask=6'b000100, limit=10, no done -> after 10 WAIT cycles: done=1, error=1, err_code=2, err_layer=2.
- During layer 3 WAIT, assert abort together with layer_done[3] -> err_code=1, err_layer=3, layer 4 not launched. Separately, layer_done[1] while layer_sel=3 -> err_code=3.
- Edge cases:
  - mask=0 -> done next cycle, error=0, cycle_count=0.
  - init asserted while busy -> no effect.
  - rstn=0 mid-WAIT -> all outputs 0 next cycle, no done pulse.
